// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - data memory port A arbiter between the CPU memory stage and a DMA master
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata        CPU access request (one access per cycle)
//   cpu_stall                    CPU request lost arbitration; pipeline holds
//   cpu_rdata/cpu_rvalid         CPU read return, one cycle after grant
//   dma_req/lock/we/addr/wdata   DMA access request; lock keeps the port across beats
//   dma_gnt                      DMA beat accepted this cycle
//   dma_rdata/dma_rvalid         DMA read return, one cycle after grant
//   mem_we/mem_addr/mem_wdata    dataMemory port A controls
//   mem_q                        dataMemory port A registered read data

module data_mem_arbiter #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dma_req,
    input  logic              dma_lock,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN} arbState_t;
    typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_DMA} rdOwner_t;

    arbState_t            state, stateNext;
    rdOwner_t             rdOwner, rdOwnerNext;
    logic [WAIT_W-1:0]    waitCnt, waitNext;
    logic [BURST_W-1:0]   burstCnt, burstNext;
    logic [ADDR_W-1:0]    lastAddr;
    logic                 cpuGrant, dmaGrant;
    logic                 burstPreempt;

    // Grant decision. Grants are forced low while reset is asserted so every
    // combinational output is quiet during reset, not just the registered ones.
    always_comb begin
        cpuGrant = 1'b0;
        dmaGrant = 1'b0;
        if (rst) begin
            if (cpu_req && dma_req) begin
                if (state == DMA_OWN) begin
                    dmaGrant = (burstCnt != BURST_LIM);
                end else begin
                    dmaGrant = (waitCnt == WAIT_LIM);
                end
                cpuGrant = ~dmaGrant;
            end else begin
                cpuGrant = cpu_req;
                dmaGrant = dma_req;
            end
        end
    end

    // A CPU slot stolen from a still-locked DMA burst is a single cycle: the
    // port stays DMA_OWN so the burst resumes right after it.
    assign burstPreempt = (state == DMA_OWN) && cpuGrant && dma_req && dma_lock;

    always_comb begin
        stateNext = IDLE;
        if (dmaGrant && dma_lock) begin
            stateNext = DMA_OWN;
        end else if (burstPreempt) begin
            stateNext = DMA_OWN;
        end else if (cpuGrant) begin
            stateNext = CPU_OWN;
        end

        waitNext = '0;
        if (dma_req && !dmaGrant) begin
            waitNext = (waitCnt == WAIT_LIM) ? WAIT_LIM : waitCnt + 1'b1;
        end

        // Only locked DMA beats keep counting; any CPU grant or leaving the
        // locked burst starts the count over.
        burstNext = '0;
        if (dmaGrant && dma_lock) begin
            burstNext = (burstCnt == BURST_LIM) ? BURST_LIM : burstCnt + 1'b1;
        end

        rdOwnerNext = RD_NONE;
        if (cpuGrant && !cpu_we) begin
            rdOwnerNext = RD_CPU;
        end else if (dmaGrant && !dma_we) begin
            rdOwnerNext = RD_DMA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            waitCnt  <= '0;
            burstCnt <= '0;
            rdOwner  <= RD_NONE;
            lastAddr <= '0;
        end else begin
            state    <= stateNext;
            waitCnt  <= waitNext;
            burstCnt <= burstNext;
            rdOwner  <= rdOwnerNext;
            if (cpuGrant || dmaGrant) begin
                lastAddr <= mem_addr;
            end
        end
    end

    // Port A mux; the address holds when idle to avoid needless toggling.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = lastAddr;
        mem_wdata = '0;
        if (cpuGrant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dmaGrant) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_stall  = rst & cpu_req & ~cpuGrant;
    assign dma_gnt    = dmaGrant;
    assign cpu_rvalid = (rdOwner == RD_CPU);
    assign dma_rvalid = (rdOwner == RD_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
    assign dma_rdata  = dma_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed bench for data_mem_arbiter

module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [18:0] cpu_addr;
    logic [23:0] cpu_wdata;
    logic        cpu_stall;
    logic [23:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        dma_req, dma_lock, dma_we;
    logic [18:0] dma_addr;
    logic [23:0] dma_wdata;
    logic        dma_gnt;
    logic [23:0] dma_rdata;
    logic        dma_rvalid;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_q;

    int errCnt = 0;
    int chkCnt = 0;

    data_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .dma_req    (dma_req),
        .dma_lock   (dma_lock),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: unwritten words read back as 0xA000xx (xx = low address byte).
    logic [23:0]  memData [0:255];
    logic [255:0] memValid;
    always @(posedge clk) begin
        if (!rst) begin
            memValid <= '0;
        end else if (mem_we) begin
            memData[mem_addr[7:0]]  <= mem_wdata;
            memValid[mem_addr[7:0]] <= 1'b1;
        end
        mem_q <= memValid[mem_addr[7:0]] ? memData[mem_addr[7:0]] : {16'hA000, mem_addr[7:0]};
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [16:0] burstPat;
    int          beat;

    initial begin
        rst = 1'b0;
        idleInputs();
        cpu_req = 1'b1;
        #2;
        checkVal("rst_cpu_stall", 32'(cpu_stall), 0);
        checkVal("rst_dma_gnt", 32'(dma_gnt), 0);
        checkVal("rst_mem_we", 32'(mem_we), 0);
        checkVal("rst_mem_addr", 32'(mem_addr), 0);
        checkVal("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        checkVal("rst_dma_rvalid", 32'(dma_rvalid), 0);
        cpu_req = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // 1: lone CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        @(negedge clk);
        checkVal("t1_stall", 32'(cpu_stall), 0);
        checkVal("t1_mem_addr", 32'(mem_addr), 'h10);
        checkVal("t1_mem_we", 32'(mem_we), 0);
        tick();
        idleInputs();
        @(negedge clk);
        checkVal("t1_cpu_rvalid", 32'(cpu_rvalid), 1);
        checkVal("t1_cpu_rdata", 32'(cpu_rdata), 'hA00010);
        checkVal("t1_dma_rvalid", 32'(dma_rvalid), 0);
        checkVal("t1_addr_hold", 32'(mem_addr), 'h10);
        tick();

        // 2: both requesting, unlocked DMA gets every fifth cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        dma_req = 1'b1; dma_lock = 1'b0; dma_we = 1'b1; dma_addr = 19'h00040; dma_wdata = 24'h777777;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkVal($sformatf("t2_dma_gnt[%0d]", c), 32'(dma_gnt), (c % 5 == 4) ? 1 : 0);
            checkVal($sformatf("t2_cpu_stall[%0d]", c), 32'(cpu_stall), (c % 5 == 4) ? 1 : 0);
            tick();
        end
        idleInputs();
        tick();

        // 3: 12-beat locked DMA write burst against a held CPU request
        burstPat = 17'b1111_0_11111111_0000;
        beat = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        dma_lock = 1'b1; dma_we = 1'b1;
        for (int c = 0; c < 17; c++) begin
            dma_req   = (beat < 12);
            dma_addr  = 19'(32'h80 + beat);
            dma_wdata = 24'(32'hD00000 + beat);
            @(negedge clk);
            checkVal($sformatf("t3_dma_gnt[%0d]", c), 32'(dma_gnt), 32'(burstPat[c]));
            checkVal($sformatf("t3_cpu_stall[%0d]", c), 32'(cpu_stall), 32'(burstPat[c]));
            if (dma_gnt) beat++;
            tick();
        end
        idleInputs();
        checkVal("t3_beats", beat, 12);
        checkVal("t3_last_written", 32'(memValid[8'h8B]), 1);
        checkVal("t3_last_data", 32'(memData[8'h8B]), 'hD0000B);
        tick();

        // 4: alternating reads CPU, DMA, CPU
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00004;
        @(negedge clk);
        checkVal("t4_c0_stall", 32'(cpu_stall), 0);
        tick();
        idleInputs();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 19'h00008;
        @(negedge clk);
        checkVal("t4_c1_dma_gnt", 32'(dma_gnt), 1);
        checkVal("t4_c1_cpu_rvalid", 32'(cpu_rvalid), 1);
        checkVal("t4_c1_cpu_rdata", 32'(cpu_rdata), 'hA00004);
        checkVal("t4_c1_dma_rvalid", 32'(dma_rvalid), 0);
        tick();
        idleInputs();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h0000C;
        @(negedge clk);
        checkVal("t4_c2_dma_rvalid", 32'(dma_rvalid), 1);
        checkVal("t4_c2_dma_rdata", 32'(dma_rdata), 'hA00008);
        checkVal("t4_c2_cpu_rvalid", 32'(cpu_rvalid), 0);
        tick();
        idleInputs();
        @(negedge clk);
        checkVal("t4_c3_cpu_rvalid", 32'(cpu_rvalid), 1);
        checkVal("t4_c3_cpu_rdata", 32'(cpu_rdata), 'hA0000C);
        checkVal("t4_c3_dma_rvalid", 32'(dma_rvalid), 0);
        tick();

        // 5: asynchronous reset during a locked DMA read
        dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 19'h00030;
        @(negedge clk);
        checkVal("t5_dma_gnt", 32'(dma_gnt), 1);
        tick();
        checkVal("t5_inflight", 32'(dma_rvalid), 1);
        #2;
        rst = 1'b0;
        #1;
        checkVal("t5_rst_dma_gnt", 32'(dma_gnt), 0);
        checkVal("t5_rst_dma_rvalid", 32'(dma_rvalid), 0);
        checkVal("t5_rst_mem_addr", 32'(mem_addr), 0);
        checkVal("t5_rst_mem_we", 32'(mem_we), 0);
        tick();
        idleInputs();
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkVal("t5_post_dma_rvalid", 32'(dma_rvalid), 0);
        checkVal("t5_post_cpu_rvalid", 32'(cpu_rvalid), 0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00010;
        dma_req = 1'b1; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = 19'h00030;
        @(negedge clk);
        checkVal("t5_first_cpu_stall", 32'(cpu_stall), 0);
        checkVal("t5_first_dma_gnt", 32'(dma_gnt), 0);
        tick();
        idleInputs();
        tick();

        // 6: DMA write then CPU read of the same word
        dma_req = 1'b1; dma_lock = 1'b0; dma_we = 1'b1; dma_addr = 19'h00020; dma_wdata = 24'h123456;
        @(negedge clk);
        checkVal("t6_dma_gnt", 32'(dma_gnt), 1);
        checkVal("t6_mem_we", 32'(mem_we), 1);
        checkVal("t6_mem_addr", 32'(mem_addr), 'h20);
        checkVal("t6_mem_wdata", 32'(mem_wdata), 'h123456);
        tick();
        idleInputs();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00020;
        @(negedge clk);
        checkVal("t6_cpu_stall", 32'(cpu_stall), 0);
        checkVal("t6_rd_mem_we", 32'(mem_we), 0);
        tick();
        idleInputs();
        @(negedge clk);
        checkVal("t6_cpu_rvalid", 32'(cpu_rvalid), 1);
        checkVal("t6_cpu_rdata", 32'(cpu_rdata), 'h123456);
        tick();

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
